dmem_ldst_seq: RTL
==================

// Module: dmem_ldst_seq
// PURPOSE
//  Initiator side of the TPU data-memory load/store channel: sequences one strided load or store per command.
//  Sits in the TPU core between the issue stage and one DMem load/store port.
//  Raises the request and length/stride/base to DMem, waits for ready/grant, streams or collects exactly LEN elements.
//  Reports completion to the core. The design instantiates one sequencer per port (2 per TPU).
// PARAMETERS
//  WIDTH_ADDR  16  base/stride/element address width
//  WIDTH_LEN   16  element-count width
//  WIDTH_DATA  32  element data width
// PORTS
//  clock        in   1           single clock, rising edge
//  reset        in   1           asynchronous, active-high reset
//  I_Cmd_Valid  in   1           core presents a command
//  I_Cmd_St     in   1           1=store, 0=load
//  I_Cmd_Base   in   WIDTH_ADDR  first element address
//  I_Cmd_Stride in   WIDTH_ADDR  address increment per element
//  I_Cmd_Len    in   WIDTH_LEN   element count
//  I_Abort      in   1           cancel current command
//  O_Cmd_Ack    out  1           command accepted this cycle
//  O_Busy       out  1           state != IDLE
//  O_Done       out  1           1-cycle completion pulse
//  O_Err        out  1           1-cycle pulse: load beat outside XFER, dropped
//  O_Req/O_St   out  1/1         DMem request; O_St=1 store, 0 load
//  O_Base/O_Stride out WIDTH_ADDR  latched command fields to DMem
//  O_Len        out  WIDTH_LEN   latched count to DMem
//  I_Ready      in   1           DMem port ready to service
//  I_Grant      in   1           DMem grants the request
//  I_St_Valid   in   1           core store beat valid
//  I_St_Data    in   WIDTH_DATA  core store data
//  O_V          out  1           store beat valid to DMem
//  O_St_Data    out  WIDTH_DATA  store data to DMem
//  I_Ld_Valid   in   1           DMem load beat valid
//  I_Ld_Data    in   WIDTH_DATA  DMem load data
//  O_Ld_Valid   out  1           load beat valid to core
//  O_Ld_Data    out  WIDTH_DATA  load data to core
//  O_Addr       out  WIDTH_ADDR  address of current element = base + cnt*stride, mod 2^WIDTH_ADDR
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. Counters and latched fields 0. Reset mid-operation drops O_Req immediately (async).
//  FSM: IDLE, WAIT_RDY, REQ, XFER, DONE.
//  IDLE: O_Cmd_Ack=I_Cmd_Valid (combinational).
//   On ack: latch St/Base/Stride/Len and clear cnt. Go to WAIT_RDY, or to DONE if Len==0 (no DMem request).
//  WAIT_RDY: I_Ready=1 -> REQ.
//  REQ: O_Req=1 (registered, first high one cycle after entry); fields stable while O_Req=1.
//   I_Grant=1 while O_Req=1 -> XFER next cycle; O_Req low in XFER.
//  XFER store: each cycle with I_St_Valid=1 registers O_V=1 and O_St_Data=I_St_Data (1-cycle latency); cnt++.
//  XFER load: each I_Ld_Valid=1 registers O_Ld_Valid=1 and O_Ld_Data=I_Ld_Data (1-cycle latency); cnt++.
//  XFER exit: the beat making cnt==Len moves to DONE. Beats beyond Len are not accepted; the core must not send them.
//  DONE: O_Done=1 for one cycle -> IDLE. A new command may be acked in the next cycle (IDLE).
//  Arithmetic: O_Addr tracks base + cnt*stride by accumulation; wraps modulo 2^WIDTH_ADDR. Stride 0 is legal.
//  Len is a full WIDTH_LEN value; max 2^WIDTH_LEN-1 elements.
//  I_Abort (any non-IDLE state, priority over all events): IDLE next cycle, O_Req=0, no O_Done, beat that cycle dropped.
//  I_Ld_Valid outside XFER: O_Err pulse, data dropped. I_St_Valid outside XFER: ignored.
//  I_Grant without O_Req: ignored. Ready deasserting in REQ: keep O_Req until grant.
// TESTING
//  Store Base=0x0100 Stride=4 Len=3, ready+grant immediate, 3 back-to-back St beats ->
//   O_V 3 cycles, O_Addr 0x100/0x104/0x108, O_Done 1 cycle after last O_V.
//  Load Len=4, I_Ready held low 5 cycles -> O_Req stays 0 until ready; after grant, 4 beats with gaps ->
//   4 O_Ld_Valid pulses with matching data, then O_Done.
//  Len=0 command -> O_Cmd_Ack, no O_Req ever, O_Done two cycles after ack.
//  Base=0xFFF8 Stride=8 Len=3 -> O_Addr 0xFFF8, 0x0000, 0x0008 (wrap).
//  I_Abort in REQ and again mid-XFER (cnt=2 of 5) -> IDLE next cycle, O_Req=0, no O_Done; next command runs normally.
//  Async reset asserted mid-XFER between edges -> all outputs 0 immediately; I_Ld_Valid in IDLE -> O_Err pulse.

Source files
------------

// File: rtl/dmem_ldst_seq.sv
// Strided load/store sequencer between the TPU issue stage and one DMem load/store port.
// Accepts one command, negotiates ready/grant, then moves exactly Len beats and pulses O_Done.
module dmem_ldst_seq #(
  parameter int WIDTH_ADDR = 16,
  parameter int WIDTH_LEN  = 16,
  parameter int WIDTH_DATA = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Cmd_Valid,
  input  logic                  I_Cmd_St,
  input  logic [WIDTH_ADDR-1:0] I_Cmd_Base,
  input  logic [WIDTH_ADDR-1:0] I_Cmd_Stride,
  input  logic [WIDTH_LEN-1:0]  I_Cmd_Len,
  input  logic                  I_Abort,
  output logic                  O_Cmd_Ack,
  output logic                  O_Busy,
  output logic                  O_Done,
  output logic                  O_Err,
  output logic                  O_Req,
  output logic                  O_St,
  output logic [WIDTH_ADDR-1:0] O_Base,
  output logic [WIDTH_ADDR-1:0] O_Stride,
  output logic [WIDTH_LEN-1:0]  O_Len,
  input  logic                  I_Ready,
  input  logic                  I_Grant,
  input  logic                  I_St_Valid,
  input  logic [WIDTH_DATA-1:0] I_St_Data,
  output logic                  O_V,
  output logic [WIDTH_DATA-1:0] O_St_Data,
  input  logic                  I_Ld_Valid,
  input  logic [WIDTH_DATA-1:0] I_Ld_Data,
  output logic                  O_Ld_Valid,
  output logic [WIDTH_DATA-1:0] O_Ld_Data,
  output logic [WIDTH_ADDR-1:0] O_Addr
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, REQ, XFER, DONE} state_t;

  state_t                state_q;
  logic                  req_q, st_q, done_q, err_q, v_q, ldv_q;
  logic [WIDTH_ADDR-1:0] base_q, stride_q, addr_q;
  logic [WIDTH_LEN-1:0]  len_q, cnt_q;
  logic [WIDTH_DATA-1:0] sdata_q, ldata_q;

  logic                  beat;
  logic                  abort;
  logic [WIDTH_LEN-1:0]  cnt_d;

  assign beat  = (state_q == XFER) && (st_q ? I_St_Valid : I_Ld_Valid);
  assign abort = (state_q != IDLE) && I_Abort;
  assign cnt_d = cnt_q + 1'b1;

  // Ack is combinational so the core can retire the command in the same cycle.
  assign O_Cmd_Ack  = (state_q == IDLE) && I_Cmd_Valid && !reset;
  assign O_Busy     = (state_q != IDLE);
  assign O_Done     = done_q;
  assign O_Err      = err_q;
  assign O_Req      = req_q;
  assign O_St       = st_q;
  assign O_Base     = base_q;
  assign O_Stride   = stride_q;
  assign O_Len      = len_q;
  assign O_V        = v_q;
  assign O_St_Data  = sdata_q;
  assign O_Ld_Valid = ldv_q;
  assign O_Ld_Data  = ldata_q;
  assign O_Addr     = addr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      st_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      v_q      <= 1'b0;
      ldv_q    <= 1'b0;
      base_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      sdata_q  <= '0;
      ldata_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      v_q    <= 1'b0;
      ldv_q  <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
      end else begin
        err_q <= I_Ld_Valid && (state_q != XFER);
        case (state_q)
          IDLE: if (I_Cmd_Valid) begin
            st_q     <= I_Cmd_St;
            base_q   <= I_Cmd_Base;
            stride_q <= I_Cmd_Stride;
            len_q    <= I_Cmd_Len;
            cnt_q    <= '0;
            addr_q   <= I_Cmd_Base;
            state_q  <= (I_Cmd_Len == '0) ? DONE : WAIT_RDY;
          end
          WAIT_RDY: if (I_Ready) state_q <= REQ;
          // Request rises one cycle after entry and holds until granted, even if ready drops.
          REQ: begin
            if (!req_q) begin
              req_q <= 1'b1;
            end else if (I_Grant) begin
              req_q   <= 1'b0;
              state_q <= XFER;
            end
          end
          XFER: if (beat) begin
            if (st_q) begin
              v_q     <= 1'b1;
              sdata_q <= I_St_Data;
            end else begin
              ldv_q   <= 1'b1;
              ldata_q <= I_Ld_Data;
            end
            cnt_q  <= cnt_d;
            addr_q <= addr_q + stride_q;
            if (cnt_d == len_q) state_q <= DONE;
          end
          DONE: begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
